// File: rtl/lfsr_frame_collector_pkg.sv
// Shared definitions for the lighthouse LFSR frame collector: window width,
// candidate polynomials, FSM encoding and the LFSR feedback prediction helper.
package lfsr_frame_collector_pkg;

    localparam int LFSR_WIDTH = 17;
    localparam int CNT_WIDTH  = 6;

    localparam logic [LFSR_WIDTH-1:0] POLY_A_DEFAULT = 17'h1d258;
    localparam logic [LFSR_WIDTH-1:0] POLY_B_DEFAULT = 17'h17e04;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_REQ     = 3'd3,
        ST_WAIT    = 3'd4
    } state_e;

    // Next LFSR output bit: parity of the window bits selected by the polynomial taps.
    function automatic logic lfsr_predict(input logic [LFSR_WIDTH-1:0] window,
                                          input logic [LFSR_WIDTH-1:0] poly);
        return ^(window & poly);
    endfunction

endpackage

// File: rtl/lfsr_frame_collector_predict.sv
// Combinational next-bit predictor for one candidate polynomial.
module lfsr_frame_collector_predict
    import lfsr_frame_collector_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0] window,
    input  logic [LFSR_WIDTH-1:0] poly,
    output logic                  pred
);

    assign pred = lfsr_predict(window, poly);

endmodule

// File: rtl/lfsr_frame_collector.sv
// Collects a 17-bit LFSR window from the demodulated sweep bitstream, identifies
// the generating polynomial and hands {data, polynomial} to the offset search stage.
module lfsr_frame_collector
    import lfsr_frame_collector_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] POLY_A      = POLY_A_DEFAULT,
    parameter logic [LFSR_WIDTH-1:0] POLY_B      = POLY_B_DEFAULT,
    parameter int                    CHECK_BITS  = 16,
    parameter int                    ACK_TIMEOUT = 1024
) (
    input  logic                  clk_96MHz,
    input  logic                  reset_n,
    input  logic                  envelope,
    input  logic                  bit_valid,
    input  logic                  bit_value,
    input  logic                  finder_ready,
    output logic                  finder_enable,
    output logic [LFSR_WIDTH-1:0] data,
    output logic [LFSR_WIDTH-1:0] polynomial,
    output logic                  poly_id,
    output logic                  frame_error
);

    localparam int                   TO_WIDTH     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] COLLECT_LAST = CNT_WIDTH'(LFSR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CHECK_LAST   = CNT_WIDTH'(CHECK_BITS);
    localparam logic [TO_WIDTH-1:0]  TO_LAST      = TO_WIDTH'(ACK_TIMEOUT - 1);

    state_e                state_r, state_nxt_s;
    logic [LFSR_WIDTH-1:0] window_r, window_nxt_s;
    logic [CNT_WIDTH-1:0]  bit_cnt_r;
    logic [TO_WIDTH-1:0]   to_cnt_r;
    logic                  match_a_r, match_b_r, envelope_d_r;
    logic                  pred_a_s, pred_b_s, bit_acc_s;
    logic                  start_s, err_s, latch_data_s, latch_poly_s;
    logic                  finder_enable_r, poly_id_r, frame_error_r;
    logic [LFSR_WIDTH-1:0] data_r, polynomial_r;

    lfsr_frame_collector_predict u_pred_a (.window(window_r), .poly(POLY_A), .pred(pred_a_s));
    lfsr_frame_collector_predict u_pred_b (.window(window_r), .poly(POLY_B), .pred(pred_b_s));

    assign bit_acc_s    = bit_valid && envelope && ((state_r == ST_COLLECT) || (state_r == ST_CHECK));
    assign window_nxt_s = {window_r[LFSR_WIDTH-2:0], bit_value};

    // State register.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; an envelope drop takes priority over any bit in the same cycle.
    always_comb begin
        state_nxt_s  = state_r;
        start_s      = 1'b0;
        err_s        = 1'b0;
        latch_data_s = 1'b0;
        latch_poly_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (envelope && !envelope_d_r) begin
                    state_nxt_s = ST_COLLECT;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (!envelope) begin
                    state_nxt_s = ST_IDLE;
                    err_s       = 1'b1;
                end else if (bit_acc_s && (bit_cnt_r == COLLECT_LAST)) begin
                    latch_data_s = 1'b1;
                    if (window_nxt_s == {LFSR_WIDTH{1'b0}}) begin
                        state_nxt_s = ST_IDLE;
                        err_s       = 1'b1;
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_CHECK: begin
                if (!envelope || (!match_a_r && !match_b_r)) begin
                    state_nxt_s = ST_IDLE;
                    err_s       = 1'b1;
                end else if (bit_cnt_r == CHECK_LAST) begin
                    if (match_a_r ^ match_b_r) begin
                        state_nxt_s  = ST_REQ;
                        latch_poly_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        err_s       = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_REQ: begin
                if (!finder_ready) begin
                    state_nxt_s = ST_WAIT;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = ST_IDLE;
                    err_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (finder_ready) begin
                    state_nxt_s = ST_IDLE;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = ST_IDLE;
                    err_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Window, counters and match flags; counters restart on every state change.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            envelope_d_r <= 1'b0;
            window_r     <= {LFSR_WIDTH{1'b0}};
            bit_cnt_r    <= {CNT_WIDTH{1'b0}};
            to_cnt_r     <= {TO_WIDTH{1'b0}};
            match_a_r    <= 1'b0;
            match_b_r    <= 1'b0;
        end else begin
            envelope_d_r <= envelope;
            if (start_s) begin
                window_r <= {LFSR_WIDTH{1'b0}};
            end else if (bit_acc_s) begin
                window_r <= window_nxt_s;
            end else begin
                window_r <= window_r;
            end
            if (state_nxt_s != state_r) begin
                bit_cnt_r <= {CNT_WIDTH{1'b0}};
                to_cnt_r  <= {TO_WIDTH{1'b0}};
            end else begin
                if (bit_acc_s && (bit_cnt_r != CNT_MAX)) begin
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                end else begin
                    bit_cnt_r <= bit_cnt_r;
                end
                if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
                    to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
                end else begin
                    to_cnt_r <= to_cnt_r;
                end
            end
            if (start_s) begin
                match_a_r <= 1'b1;
                match_b_r <= 1'b1;
            end else if ((state_r == ST_CHECK) && bit_acc_s && (bit_cnt_r < CHECK_LAST)) begin
                match_a_r <= match_a_r && (bit_value == pred_a_s);
                match_b_r <= match_b_r && (bit_value == pred_b_s);
            end else begin
                match_a_r <= match_a_r;
                match_b_r <= match_b_r;
            end
        end
    end

    // Registered outputs toward the offset search stage.
    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            finder_enable_r <= 1'b0;
            frame_error_r   <= 1'b0;
            data_r          <= {LFSR_WIDTH{1'b0}};
            polynomial_r    <= {LFSR_WIDTH{1'b0}};
            poly_id_r       <= 1'b0;
        end else begin
            finder_enable_r <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_WAIT);
            frame_error_r   <= err_s;
            if (latch_data_s) begin
                data_r <= window_nxt_s;
            end else begin
                data_r <= data_r;
            end
            if (latch_poly_s) begin
                polynomial_r <= match_b_r ? POLY_B : POLY_A;
                poly_id_r    <= match_b_r;
            end else begin
                polynomial_r <= polynomial_r;
                poly_id_r    <= poly_id_r;
            end
        end
    end

    assign finder_enable = finder_enable_r;
    assign frame_error   = frame_error_r;
    assign data          = data_r;
    assign polynomial    = polynomial_r;
    assign poly_id       = poly_id_r;

endmodule

// File: tb/tb_lfsr_frame_collector.sv
// Directed self-checking bench for lfsr_frame_collector.
`timescale 1ns/1ps
module tb_lfsr_frame_collector;

    localparam logic [16:0] P_A  = 17'h1d258;
    localparam logic [16:0] P_B  = 17'h17e04;
    localparam logic [16:0] SEED = 17'h00001;

    logic        clk_96MHz = 1'b0;
    logic        reset_n, envelope, bit_valid, bit_value, finder_ready;
    logic        finder_enable, poly_id, frame_error;
    logic [16:0] data, polynomial;

    int errors   = 0;
    int checks   = 0;
    int err_seen = 0;
    int en_seen  = 0;
    int e0, n0;

    always #5 clk_96MHz = ~clk_96MHz;

    lfsr_frame_collector #(
        .POLY_A(P_A), .POLY_B(P_B), .CHECK_BITS(16), .ACK_TIMEOUT(1024)
    ) dut (
        .clk_96MHz(clk_96MHz), .reset_n(reset_n), .envelope(envelope),
        .bit_valid(bit_valid), .bit_value(bit_value), .finder_ready(finder_ready),
        .finder_enable(finder_enable), .data(data), .polynomial(polynomial),
        .poly_id(poly_id), .frame_error(frame_error)
    );

    // Count error-pulse cycles and request cycles, sampled mid-cycle.
    always @(negedge clk_96MHz) begin
        if (frame_error === 1'b1) err_seen <= err_seen + 1;
        if (finder_enable === 1'b1) en_seen <= en_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk_96MHz); #1;
        bit_valid = 1'b1;
        bit_value = b;
        @(posedge clk_96MHz); #1;
        bit_valid = 1'b0;
        bit_value = 1'b0;
    endtask

    // Raise envelope, send the seed MSB first, then n_check generated bits (one optionally flipped).
    task automatic send_frame(input logic [16:0] seed, input logic [16:0] poly,
                              input int n_check, input int flip_idx);
        logic [16:0] w;
        logic        b;
        @(posedge clk_96MHz); #1;
        envelope = 1'b1;
        for (int i = 16; i >= 0; i--) send_bit(seed[i]);
        w = seed;
        for (int i = 0; i < n_check; i++) begin
            b = ^(w & poly);
            if (i == flip_idx) b = ~b;
            send_bit(b);
            w = {w[15:0], b};
        end
    endtask

    task automatic handshake(input int low_cycles, input logic [16:0] exp_data, input logic [16:0] exp_poly);
        int unstable = 0;
        @(posedge clk_96MHz); #1;
        finder_ready = 1'b0;
        for (int i = 0; i < low_cycles; i++) begin
            @(posedge clk_96MHz); #1;
            if (data !== exp_data || polynomial !== exp_poly || finder_enable !== 1'b1) unstable++;
        end
        finder_ready = 1'b1;
        check_eq("hs_stable", unstable, 0);
        @(posedge clk_96MHz); #1;
        check_eq("hs_enable_fall", finder_enable, 1'b0);
        check_eq("hs_data_after", data, exp_data);
    endtask

    task automatic idle_low();
        envelope = 1'b0;
        repeat (3) @(posedge clk_96MHz);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; envelope = 1'b0; bit_valid = 1'b0; bit_value = 1'b0; finder_ready = 1'b1;
        repeat (2) @(posedge clk_96MHz);
        #1;
        check_eq("rst_enable", finder_enable, 1'b0);
        check_eq("rst_error", frame_error, 1'b0);
        check_eq("rst_data", data, 17'h00000);
        check_eq("rst_poly", polynomial, 17'h00000);
        check_eq("rst_id", poly_id, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_96MHz);

        // Poly A frame with a 40-cycle handshake
        e0 = err_seen;
        send_frame(SEED, P_A, 16, -1);
        check_eq("a_lat1", finder_enable, 1'b0);
        @(posedge clk_96MHz); #1;
        check_eq("a_lat2", finder_enable, 1'b1);
        check_eq("a_data", data, SEED);
        check_eq("a_poly", polynomial, P_A);
        check_eq("a_id", poly_id, 1'b0);
        handshake(40, SEED, P_A);
        check_eq("a_no_err", err_seen - e0, 0);
        idle_low();

        // Poly B frame
        send_frame(SEED, P_B, 16, -1);
        @(posedge clk_96MHz); #1;
        check_eq("b_enable", finder_enable, 1'b1);
        check_eq("b_poly", polynomial, P_B);
        check_eq("b_id", poly_id, 1'b1);
        handshake(3, SEED, P_B);
        idle_low();

        // Reset in the middle of CHECK
        e0 = err_seen;
        send_frame(SEED, P_B, 3, -1);
        check_eq("pre_rst_data", data, SEED);
        reset_n = 1'b0;
        envelope = 1'b0;
        #1;
        check_eq("mid_rst_enable", finder_enable, 1'b0);
        check_eq("mid_rst_data", data, 17'h00000);
        check_eq("mid_rst_poly", polynomial, 17'h00000);
        check_eq("mid_rst_id", poly_id, 1'b0);
        repeat (3) @(posedge clk_96MHz);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_96MHz);
        #1;
        check_eq("mid_rst_no_err", err_seen - e0, 0);
        send_frame(SEED, P_B, 16, -1);
        @(posedge clk_96MHz); #1;
        check_eq("restart_enable", finder_enable, 1'b1);
        check_eq("restart_poly", polynomial, P_B);
        check_eq("restart_id", poly_id, 1'b1);
        handshake(3, SEED, P_B);
        idle_low();

        // Corrupted 5th check bit
        e0 = err_seen; n0 = en_seen;
        send_frame(SEED, P_A, 16, 4);
        repeat (4) @(posedge clk_96MHz);
        #1;
        check_eq("corrupt_err", err_seen - e0, 1);
        check_eq("corrupt_no_en", en_seen - n0, 0);
        idle_low();

        // Envelope falls after 10 bits
        e0 = err_seen; n0 = en_seen;
        @(posedge clk_96MHz); #1;
        envelope = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        envelope = 1'b0;
        repeat (4) @(posedge clk_96MHz);
        #1;
        check_eq("abort_err", err_seen - e0, 1);
        check_eq("abort_no_en", en_seen - n0, 0);

        // All-zero window
        e0 = err_seen; n0 = en_seen;
        send_frame(17'h00000, P_A, 0, -1);
        repeat (4) @(posedge clk_96MHz);
        #1;
        check_eq("zero_err", err_seen - e0, 1);
        check_eq("zero_no_en", en_seen - n0, 0);
        idle_low();

        // Handshake timeout with finder_ready stuck high
        e0 = err_seen; n0 = en_seen;
        send_frame(SEED, P_A, 16, -1);
        repeat (1040) @(posedge clk_96MHz);
        #1;
        check_eq("to_en_cycles", en_seen - n0, 1024);
        check_eq("to_err", err_seen - e0, 1);
        check_eq("to_enable_low", finder_enable, 1'b0);
        idle_low();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
